// File: rtl/crc_pkg.sv
// Shared CRC-32 (IEEE 802.3) definitions for the MAC FCS generator and the
// future receive-path checker.
//   CRC32_POLY_REFL : reflected polynomial (normal form 0x04C11DB7)
//   CRC32_INIT      : register seed
//   CRC32_XOR_OUT   : final complement applied to the output view
//   crc32_byte()    : one byte through the reflected (LSB-first) register
//   bitrev32()      : 32-bit bit reversal
package crc_pkg;

  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_XOR_OUT   = 32'hFFFFFFFF;

  // Bit 0 of d is the first bit on the wire, so it is absorbed first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0]  d,
                                             input logic [31:0] poly = CRC32_POLY_REFL);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = (r >> 1) ^ (fb ? poly : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [31:0] bitrev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = x[i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_byte_step.sv
// Pure combinational next-state for a byte-serial reflected CRC-32.
// All eight bit iterations collapse into one XOR network.
//   crc   in  32  current reflected register
//   data  in   8  byte, bit 0 first on the wire
//   next  out 32  register after absorbing data
module crc32_byte_step
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY_REFL = CRC32_POLY_REFL
) (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] next
);

  always_comb begin
    next = crc32_byte(crc, data, POLY_REFL);
  end

endmodule

// File: rtl/crc32_eth.sv
// Byte-serial IEEE 802.3 FCS generator for the MII transmit path.
// One byte absorbed per clock when data_valid is high; no stall, no handshake.
// The only way to re-seed is rstn; the caller pulses it between frames.
//   clk         in   1   rising-edge clock
//   rstn        in   1   async active-low reset, seeds crc_reg with INIT
//   data_in     in   8   frame byte, bit 0 first on the wire
//   data_valid  in   1   absorb data_in on this edge
//   crc_out     out 32   running FCS in transmit order, bit 31 first on wire
module crc32_eth
  import crc_pkg::*;
#(
  parameter logic [31:0] POLY_REFL = CRC32_POLY_REFL,
  parameter logic [31:0] INIT      = CRC32_INIT,
  parameter logic [31:0] XOR_OUT   = CRC32_XOR_OUT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  data_in,
  input  logic        data_valid,
  output logic [31:0] crc_out
);

  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  crc32_byte_step #(.POLY_REFL(POLY_REFL)) u_step (
    .crc  (crc_reg),
    .data (data_in),
    .next (crc_next)
  );

  // The enable gates the load, so garbage on data_in during gaps never
  // reaches the register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)           crc_reg <= INIT;
    else if (data_valid) crc_reg <= crc_next;
  end

  // Complement and reverse so crc_out[31] is the first FCS bit on the wire;
  // MII nibble k is crc_out[31-4k:28-4k] with bit 31-4k on txd[0].
  assign crc_out = bitrev32(crc_reg ^ XOR_OUT);

endmodule

// File: tb/tb_crc32_eth.sv
// Self-checking bench for crc32_eth. The reference model is a plain
// MSB-first polynomial division over the wire bit stream (normal form
// 0x04C11DB7), whose complemented register is directly the transmit-order FCS.
module tb_crc32_eth;

  logic        clk;
  logic        rstn;
  logic [7:0]  data_in;
  logic        data_valid;
  logic [31:0] crc_out;

  int vectors;
  int miscompares;

  logic [31:0] mdl;   // normal-form model register

  crc32_eth dut (
    .clk        (clk),
    .rstn       (rstn),
    .data_in    (data_in),
    .data_valid (data_valid),
    .crc_out    (crc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] check_str [9];
  initial check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

  // Wire-order bit division: bit 0 of each byte goes first.
  function automatic logic [31:0] mdl_byte(input logic [31:0] r, input logic [7:0] d);
    logic fb;
    for (int b = 0; b < 8; b++) begin
      fb = r[31] ^ d[b];
      r  = {r[30:0], 1'b0} ^ (fb ? 32'h04C11DB7 : 32'h0);
    end
    return r;
  endfunction

  function automatic logic [31:0] rev(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

  // All drivers run from posedge+1, sampling at the next posedge+1.
  task automatic put_byte(input logic [7:0] d);
    data_in    = d;
    data_valid = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    mdl = mdl_byte(mdl, d);
  endtask

  task automatic put_gap();
    data_in    = 8'($urandom);
    data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Asynchronous pulse between edges; crc_out checked while rstn is low.
  task automatic pulse_reset(input string tag);
    rstn = 1'b0;
    #2;
    vectors++;
    if (crc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL %s_async_reset: got %08h want %08h", tag, crc_out, 32'h0);
    end
    #2;
    rstn = 1'b1;
    mdl  = 32'hFFFFFFFF;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; data_valid = 1'b0; data_in = 8'h00;
    mdl = 32'hFFFFFFFF;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (crc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_low: got %08h want %08h", crc_out, 32'h0);
    end
    rstn = 1'b1;
    repeat (2) put_gap();
    vectors++;
    if (crc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release: got %08h want %08h", crc_out, 32'h0);
    end
  endtask

  task automatic test_single_zero();
    pulse_reset("zero");
    put_byte(8'h00);
    vectors++;
    if (crc_out !== 32'hB1F7404B) begin
      miscompares++;
      $display("FAIL single_zero: got %08h want %08h", crc_out, 32'hB1F7404B);
    end
    put_gap();
    vectors++;
    if (crc_out !== 32'hB1F7404B) begin
      miscompares++;
      $display("FAIL single_zero_hold: got %08h want %08h", crc_out, 32'hB1F7404B);
    end
  endtask

  task automatic test_back_to_back();
    pulse_reset("b2b");
    for (int i = 0; i < 9; i++) begin
      put_byte(check_str[i]);
      vectors++;
      if (crc_out !== ~mdl) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: got %08h want %08h", i, crc_out, ~mdl);
      end
    end
    vectors++;
    if (crc_out !== 32'h649C2FD3) begin
      miscompares++;
      $display("FAIL b2b_check: got %08h want %08h", crc_out, 32'h649C2FD3);
    end
  endtask

  task automatic test_gaps();
    pulse_reset("gaps");
    for (int i = 0; i < 9; i++) begin
      int ng;
      ng = $urandom_range(0, 3);
      for (int g = 0; g < ng; g++) begin
        put_gap();
        vectors++;
        if (crc_out !== ~mdl) begin
          miscompares++;
          $display("FAIL gaps_hold%0d: got %08h want %08h", i, crc_out, ~mdl);
        end
      end
      put_byte(check_str[i]);
    end
    vectors++;
    if (crc_out !== 32'h649C2FD3) begin
      miscompares++;
      $display("FAIL gaps_check: got %08h want %08h", crc_out, 32'h649C2FD3);
    end
  endtask

  task automatic test_mid_reset();
    pulse_reset("mid_pre");
    for (int i = 0; i < 4; i++) put_byte(check_str[i]);
    vectors++;
    if (crc_out !== ~mdl) begin
      miscompares++;
      $display("FAIL mid_partial: got %08h want %08h", crc_out, ~mdl);
    end
    pulse_reset("mid");
    vectors++;
    if (crc_out !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_after_reset: got %08h want %08h", crc_out, 32'h0);
    end
    for (int i = 0; i < 9; i++) put_byte(check_str[i]);
    vectors++;
    if (crc_out !== 32'h649C2FD3) begin
      miscompares++;
      $display("FAIL mid_check: got %08h want %08h", crc_out, 32'h649C2FD3);
    end
  endtask

  // Random frames, random gaps; every byte compared against the model,
  // then the FCS is appended LSB-first and the residue checked.
  task automatic test_residue();
    for (int f = 0; f < 3; f++) begin
      int          len;
      int          bad;
      logic [31:0] fcs;
      bad = 0;
      pulse_reset("res");
      len = (f == 0) ? 64 : (f == 1) ? 1518 : $urandom_range(65, 1517);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0) put_gap();
        put_byte(8'($urandom));
        if (crc_out !== ~mdl) bad++;
      end
      vectors++;
      if (bad != 0) begin
        miscompares++;
        $display("FAIL res_frame%0d_running: %0d bytes off, last got %08h want %08h",
                 f, bad, crc_out, ~mdl);
      end
      fcs = rev(~mdl);
      for (int k = 0; k < 4; k++) put_byte(fcs[8*k +: 8]);
      vectors++;
      if (crc_out !== 32'h38FB2284) begin
        miscompares++;
        $display("FAIL res_frame%0d_len%0d: got %08h want %08h", f, len, crc_out, 32'h38FB2284);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_zero();
    test_back_to_back();
    test_gaps();
    test_mid_reset();
    test_residue();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
